// File: rtl/program_load_controller_if.sv
// Bus bundle between the program loader, the CPU data port and the RAM data port.
// The master modport is the environment (loader source, CPU, RAM); slave is the controller.
interface program_load_controller_if #(
  parameter int COUNT_WIDTH = 10
);
  logic                   start;
  logic                   halt;
  logic [31:0]            baseAddress;
  logic [COUNT_WIDTH-1:0] wordCount;
  logic [31:0]            loadData;
  logic                   loadValid;
  logic                   loadReady;
  logic [31:0]            addressFromCPU;
  logic [31:0]            dataFromCPU;
  logic                   writeEnableFromCPU;
  logic [31:0]            toMemAddress;
  logic [31:0]            toMemWriteData;
  logic                   toMemWriteEnable;
  logic                   resetPC;
  logic                   busy;
  logic                   done;

  modport master (
    output start, halt, baseAddress, wordCount, loadData, loadValid,
           addressFromCPU, dataFromCPU, writeEnableFromCPU,
    input  loadReady, toMemAddress, toMemWriteData, toMemWriteEnable,
           resetPC, busy, done
  );

  modport slave (
    input  start, halt, baseAddress, wordCount, loadData, loadValid,
           addressFromCPU, dataFromCPU, writeEnableFromCPU,
    output loadReady, toMemAddress, toMemWriteData, toMemWriteEnable,
           resetPC, busy, done
  );
endinterface

// File: rtl/program_load_controller.sv
// Loads a word stream into consecutive RAM addresses with the CPU held in PC reset,
// then releases the CPU and passes its data-port traffic through to the RAM.
module program_load_controller #(
  parameter int ADDR_STEP     = 4,
  parameter int COUNT_WIDTH   = 10,
  parameter int RELEASE_DELAY = 2
) (
  input logic clk,
  input logic reset,
  program_load_controller_if.slave bus
);
  localparam int RW = (RELEASE_DELAY < 1) ? 1 : $clog2(RELEASE_DELAY + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

  state_t                 state, state_n;
  logic [31:0]            addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [RW-1:0]          rel_cnt;
  logic                   hs;

  assign hs            = bus.loadValid && (state == LOAD);
  assign bus.loadReady = (state == LOAD);
  assign bus.busy      = (state == LOAD) || (state == RELEASE);
  assign bus.done      = (state == RUN);
  assign bus.resetPC   = (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // RELEASE's first cycle carries the final load write; the CPU then stays held
  // for RELEASE_DELAY further cycles before RUN.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = (bus.wordCount != '0) ? LOAD : RELEASE;
      LOAD:    if (hs && remaining == COUNT_WIDTH'(1)) state_n = RELEASE;
      RELEASE: if (rel_cnt == RW'(RELEASE_DELAY)) state_n = RUN;
      RUN:     if (bus.halt) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.toMemAddress     <= '0;
      bus.toMemWriteData   <= '0;
      bus.toMemWriteEnable <= 1'b0;
      addr                 <= '0;
      remaining            <= '0;
      rel_cnt              <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.toMemAddress     <= '0;
          bus.toMemWriteData   <= '0;
          bus.toMemWriteEnable <= 1'b0;
          rel_cnt              <= '0;
          if (bus.start) begin
            addr      <= bus.baseAddress;
            remaining <= bus.wordCount;
          end
        end
        LOAD: begin
          bus.toMemWriteEnable <= hs;
          rel_cnt              <= '0;
          if (hs) begin
            bus.toMemAddress   <= addr;
            bus.toMemWriteData <= bus.loadData;
            addr               <= addr + 32'(ADDR_STEP);
            remaining          <= remaining - COUNT_WIDTH'(1);
          end
        end
        RELEASE: begin
          bus.toMemWriteEnable <= 1'b0;
          rel_cnt              <= rel_cnt + RW'(1);
        end
        RUN: begin
          if (bus.halt) begin
            bus.toMemAddress     <= '0;
            bus.toMemWriteData   <= '0;
            bus.toMemWriteEnable <= 1'b0;
          end else begin
            bus.toMemAddress     <= bus.addressFromCPU;
            bus.toMemWriteData   <= bus.dataFromCPU;
            bus.toMemWriteEnable <= bus.writeEnableFromCPU;
          end
        end
        default: bus.toMemWriteEnable <= 1'b0;
      endcase
    end
  end
endmodule
